// File: rtl/instr_queue.sv
// In-order instruction queue between decode and reservation-station dispatch.
// Circular buffer with registered status flags, flush and a one-cycle push-to-head latency.

package tomasulo_types;
   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } ctl_word;
endpackage

module instr_queue #(
   parameter int DEPTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ld_iq,
   input  tomasulo_types::ctl_word   control_word_in,
   output logic                      iq_resp,
   input  logic                      flush,
   input  logic                      issue_ready,
   output logic                      issue_valid,
   output tomasulo_types::ctl_word   control_word_out,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   tomasulo_types::ctl_word mem_r [DEPTH];

   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic          full_r;
   logic          empty_r;

   logic          push_s;
   logic          pop_s;
   logic [PW-1:0] head_nxt_s;
   logic [PW-1:0] tail_nxt_s;
   logic [CW-1:0] count_nxt_s;

   // Push never looks at issue_ready, so a full queue cannot write through on a pop.
   always_comb begin
      push_s      = ld_iq & ~full_r & ~flush & ~rst;
      pop_s       = ~empty_r & issue_ready & ~flush & ~rst;
      head_nxt_s  = head_r;
      tail_nxt_s  = tail_r;
      count_nxt_s = count_r;
      if (push_s) begin
         tail_nxt_s = tail_r + PW'(1);
      end else begin
         tail_nxt_s = tail_r;
      end
      if (pop_s) begin
         head_nxt_s = head_r + PW'(1);
      end else begin
         head_nxt_s = head_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and flags; reset and flush both clear them identically.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head_r  <= PW'(0);
         tail_r  <= PW'(0);
         count_r <= CW'(0);
         full_r  <= 1'b0;
         empty_r <= 1'b1;
      end else begin
         head_r  <= head_nxt_s;
         tail_r  <= tail_nxt_s;
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == CW'(DEPTH));
         empty_r <= (count_nxt_s == CW'(0));
      end
   end

   // Entry storage is deliberately left uncleared by reset and flush.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[tail_r] <= control_word_in;
      end
   end

   assign iq_resp          = push_s;
   assign issue_valid      = ~empty_r;
   assign control_word_out = mem_r[head_r];
   assign full             = full_r;
   assign empty            = empty_r;
   assign count            = count_r;

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: a stimulus task feeds a scoreboard queue,
// a separate monitor checks every head entry presented by the DUT.

module tb_instr_queue;
   import tomasulo_types::*;

   localparam int DEPTH = 8;

   logic          clk;
   logic          rst;
   logic          ld_iq;
   ctl_word       control_word_in;
   logic          iq_resp;
   logic          flush;
   logic          issue_ready;
   logic          issue_valid;
   ctl_word       control_word_out;
   logic          full;
   logic          empty;
   logic [3:0]    count;

   instr_queue #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .ld_iq            (ld_iq),
      .control_word_in  (control_word_in),
      .iq_resp          (iq_resp),
      .flush            (flush),
      .issue_ready      (issue_ready),
      .issue_valid      (issue_valid),
      .control_word_out (control_word_out),
      .full             (full),
      .empty            (empty),
      .count            (count)
   );

   int      tests = 0;
   int      fails = 0;
   int      m_count = 0;
   bit      armed = 1'b0;
   ctl_word sb_q [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_word mk(input logic [31:0] pc);
      ctl_word w;
      w.pc     = pc;
      w.opcode = pc[8:2];
      w.rd     = pc[6:2];
      w.rs1    = pc[11:7];
      w.rs2    = pc[4:0] ^ 5'h15;
      return w;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus with model-predicted status checks.
   task automatic cycle(input logic ld, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rs);
      bit acc;
      bit pop;
      ld_iq           = ld;
      control_word_in = mk(pc);
      issue_ready     = rdy;
      flush           = fl;
      rst             = rs;
      acc = ld && (m_count != DEPTH) && !fl && !rs;
      pop = (m_count != 0) && rdy && !fl && !rs;
      @(negedge clk);
      check("iq_resp", {63'd0, iq_resp}, {63'd0, acc});
      if (armed) begin
         check("count", {60'd0, count}, 64'(m_count));
         check("empty", {63'd0, empty}, {63'd0, m_count == 0});
         check("full", {63'd0, full}, {63'd0, m_count == DEPTH});
         check("issue_valid", {63'd0, issue_valid}, {63'd0, m_count != 0});
      end
      @(posedge clk);
      if (rs || fl) begin
         m_count = 0;
         sb_q.delete();
      end else begin
         if (acc) sb_q.push_back(mk(pc));
         m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
      end
      #1;
   endtask

   // Monitor: head entry must match scoreboard front whenever valid; pop on handshake.
   always @(negedge clk) begin
      if (armed && issue_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL head_underflow: got pc 0x%0h, expected no valid entry", control_word_out.pc);
         end else begin
            check("head_word", 64'(control_word_out), 64'(sb_q[0]));
            if (issue_ready && !flush && !rst) void'(sb_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1; ld_iq = 1'b0; flush = 1'b0; issue_ready = 1'b0;
      control_word_in = mk(32'h0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      armed = 1'b1;
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // Three pushes held, then three consecutive issues.
      cycle(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h64, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h68, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Push into empty queue while consumer is ready: no bypass.
      cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Fill, hold a push while full, then pop once.
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h80, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Steady state at count 4 with simultaneous push and pop across wraps.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 32'h310 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Flush at count 5 with push and pop requested.
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h380 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h3f0, 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Reset at count 6 with a held push.
      for (int i = 0; i < 6; i++) cycle(1'b1, 32'h480 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state changes SHALL occur on the rising edge of clk.
REQ-002 Parameter DEPTH, default 8, number of queue entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ld_iq  input  1  producer push request; held high until accepted.
REQ-006 control_word_in  input  tomasulo_types::ctl_word  entry to enqueue; sampled only when the push is accepted.
REQ-007 iq_resp  output  1  push accepted this cycle; combinational.
REQ-008 flush  input  1  discard all entries (branch mispredict / redirect).
REQ-009 issue_ready  input  1  consumer (reservation-station dispatch) can take the head entry this cycle.
REQ-010 issue_valid  output  1  head entry valid.
REQ-011 control_word_out  output  tomasulo_types::ctl_word  head entry; driven from storage, not from control_word_in.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-015 Storage: circular buffer of DEPTH ctl_word entries with head pointer, tail pointer ($clog2(DEPTH) bits, wrap modulo DEPTH) and occupancy counter.
REQ-016 Push: iq_resp = ld_iq AND NOT full AND NOT flush AND NOT rst; when iq_resp is 1, control_word_in SHALL be written at tail and tail SHALL advance by 1 at the edge.
REQ-017 Push acceptance SHALL NOT depend on issue_ready (no write-through when full, even with a simultaneous pop).
REQ-018 Producer contract: a push asserted while full SHALL be held by the producer (iq_resp 0) and SHALL be accepted in the first cycle full is 0, with no loss or duplication.
REQ-019 Pop: issue_valid = NOT empty; when issue_valid AND issue_ready, head SHALL advance by 1 at the edge.
REQ-020 issue_valid SHALL NOT depend combinationally on issue_ready or ld_iq.
REQ-021 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-022 Push to an empty queue: entry appears on control_word_out with issue_valid 1 in the next cycle (one-cycle latency, no bypass).
REQ-023 Entries SHALL issue in strict push order; control_word_out SHALL stay stable while issue_valid is 1 and issue_ready is 0.
REQ-024 Pointer wrap: after index DEPTH-1, the next index is 0; wrap SHALL NOT corrupt count, full or empty.
REQ-025 count SHALL never exceed DEPTH nor go below 0; a pop when empty has no effect.
REQ-026 Flush: at the edge, head, tail and count SHALL be set to 0; a push or pop in the same cycle SHALL be ignored (iq_resp 0); issue_valid is 0 in the following cycle.
REQ-027 Flush has priority over push and pop; rst has priority over flush.
REQ-028 Entry contents are not cleared by flush or reset; only pointers and count are.

Reset
REQ-029 With rst high at an edge: head=0, tail=0, count=0; after that edge empty=1, full=0, issue_valid=0.
REQ-030 iq_resp SHALL be 0 in any cycle where rst is 1.
REQ-031 Reset mid-operation (queue partially full, push pending) SHALL discard all entries; a held ld_iq SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-032 Reset, then push pc=0x60, 0x64, 0x68 with issue_ready=0 -> iq_resp 1 each cycle, count=3; then issue_ready=1 -> out pc 0x60, 0x64, 0x68 on consecutive cycles, then empty=1.
REQ-033 Fill DEPTH=8 entries, hold ld_iq with pc=0x80 -> iq_resp=0, full=1; pop one -> next cycle iq_resp=1, pc 0x80 enqueued last, count=8.
REQ-034 count=4, push and pop same cycle for 20 cycles with incrementing pc -> count stays 4, output order matches input, pointers wrap at least twice.
REQ-035 count=5, flush with ld_iq=1 and issue_ready=1 -> iq_resp=0, next cycle count=0, issue_valid=0; following push appears one cycle later at head.
REQ-036 Empty queue, push pc=0x100 with issue_ready=1 -> issue_valid=0 that cycle, issue_valid=1 with pc 0x100 next cycle, popped that cycle, empty=1 after.
REQ-037 count=6 with ld_iq held, assert rst 1 cycle -> iq_resp=0 during rst, count=0 after, held push accepted in first post-reset cycle.
